// File: rtl/dm_port_arbiter_if.sv
// Requester-side bundle for one data-memory port: request, command and completion.
// The master modport is the requester, the slave modport is the arbiter.
interface dm_port_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares a single-port data-memory BRAM between the core (C) and a debug/loader port (D),
// one transaction at a time, with C priority bounded by a starvation counter for D.
module dm_port_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    dm_port_arbiter_if.slave  c,
    dm_port_arbiter_if.slave  d,
    output logic              mem_clka,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta,
    output logic              busy
);

    localparam int unsigned LatW    = $clog2(RD_LAT + 1);
    localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LatW-1:0]    LatInit   = LatW'(RD_LAT);
    localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;  // 1 = D owns the transaction
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                pick_dbg;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_cnt_d = lat_cnt_q;
        starve_d  = starve_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        pick_dbg  = d.req & (~c.req | (starve_q == StarveTop));

        unique case (state_q)
            StIdle: begin
                if (c.req || d.req) begin
                    owner_d = pick_dbg;
                    we_d    = pick_dbg ? d.we    : c.we;
                    addr_d  = pick_dbg ? d.addr  : c.addr;
                    wdata_d = pick_dbg ? d.wdata : c.wdata;
                    state_d = StIssue;
                end
                // Only C wins while D waits can raise the count; it saturates at the top.
                if (!d.req || pick_dbg) begin
                    starve_d = '0;
                end else if (c.req && (starve_q != StarveTop)) begin
                    starve_d = starve_q + StarveW'(1);
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StDone;
                end else begin
                    lat_cnt_d = LatInit;
                    state_d   = StWait;
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - LatW'(1);
                if (lat_cnt_q == LatW'(1)) begin
                    if (owner_q) begin
                        d_rdata_d = mem_douta;
                    end else begin
                        c_rdata_d = mem_douta;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt_q <= '0;
            starve_q  <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_cnt_q <= lat_cnt_d;
            starve_q  <= starve_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The latch is only reloaded on a grant, so address/data hold their last issued values.
    assign mem_clka  = clk;
    assign mem_ena   = (state_q == StIssue);
    assign mem_wea   = (state_q == StIssue) & we_q;
    assign mem_addra = addr_q;
    assign mem_dina  = wdata_q;
    assign busy      = (state_q != StIdle);

    assign c.ack   = (state_q == StDone) & ~owner_q;
    assign d.ack   = (state_q == StDone) & owner_q;
    assign c.rdata = c_rdata_q;
    assign d.rdata = d_rdata_q;

    a_single_ack: assert property (@(posedge clk) disable iff (!rst) !(c.ack && d.ack));
    a_ena_busy:   assert property (@(posedge clk) disable iff (!rst) mem_ena |-> busy);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: two instances (RD_LAT 1 and 3) with behavioural BRAMs,
// a grant-order scoreboard per instance, and scenario tasks with inline checks.
module tb_dm_port_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          port;     // 1 = D expected to ack
        logic [DW-1:0] c_rdata;
        logic [DW-1:0] d_rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t sb1[$];
    exp_t sb3[$];
    logic [DW-1:0] shadow1 [128];
    logic [DW-1:0] shadow3 [128];
    logic [DW-1:0] c_exp1 = '0, d_exp1 = '0, c_exp3 = '0, d_exp3 = '0;

    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c_if ();
    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c3_if ();
    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d3_if ();

    logic          mem_clka1, mem_ena1, mem_wea1, busy1;
    logic [AW-1:0] mem_addra1;
    logic [DW-1:0] mem_dina1, mem_douta1;
    logic          mem_clka3, mem_ena3, mem_wea3, busy3;
    logic [AW-1:0] mem_addra3;
    logic [DW-1:0] mem_dina3, mem_douta3;

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .c(c_if), .d(d_if),
        .mem_clka(mem_clka1), .mem_ena(mem_ena1), .mem_wea(mem_wea1),
        .mem_addra(mem_addra1), .mem_dina(mem_dina1), .mem_douta(mem_douta1),
        .busy(busy1)
    );

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst), .c(c3_if), .d(d3_if),
        .mem_clka(mem_clka3), .mem_ena(mem_ena3), .mem_wea(mem_wea3),
        .mem_addra(mem_addra3), .mem_dina(mem_dina3), .mem_douta(mem_douta3),
        .busy(busy3)
    );

    // Behavioural BRAMs: latency 1 and latency 3.
    logic [DW-1:0] bram1 [128];
    logic [DW-1:0] bram3 [128];
    logic [DW-1:0] p0_3, p1_3;

    initial begin
        for (int i = 0; i < 128; i++) begin
            bram1[i] <= 32'hA500_0000 | DW'(i);
            bram3[i] <= 32'h3C00_0000 | DW'(i);
        end
    end

    always @(posedge clk) begin
        if (mem_ena1) begin
            if (mem_wea1) bram1[mem_addra1] <= mem_dina1;
            mem_douta1 <= bram1[mem_addra1];
        end
        if (mem_ena3) begin
            if (mem_wea3) bram3[mem_addra3] <= mem_dina3;
            p0_3 <= bram3[mem_addra3];
        end
        p1_3       <= p0_3;
        mem_douta3 <= p1_3;
    end

    // Scoreboards: every ack must match the next expected owner and both rdata values.
    always @(negedge clk) begin
        if (c_if.ack || d_if.ack) begin
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_ack c_ack=%0b d_ack=%0b required none",
                         c_if.ack, d_if.ack);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                if ({c_if.ack, d_if.ack} !== (e.port ? 2'b01 : 2'b10) ||
                    c_if.rdata !== e.c_rdata || d_if.rdata !== e.d_rdata) begin
                    errors++;
                    $display("FAIL sb1_ack c/d_ack=%0b%0b c_rdata=%h d_rdata=%h required %s c=%h d=%h",
                             c_if.ack, d_if.ack, c_if.rdata, d_if.rdata,
                             e.port ? "D" : "C", e.c_rdata, e.d_rdata);
                end
            end
        end
        if (c3_if.ack || d3_if.ack) begin
            checks++;
            if (sb3.size() == 0) begin
                errors++;
                $display("FAIL sb3_unexpected_ack c_ack=%0b d_ack=%0b required none",
                         c3_if.ack, d3_if.ack);
            end else begin
                exp_t e;
                e = sb3.pop_front();
                if ({c3_if.ack, d3_if.ack} !== (e.port ? 2'b01 : 2'b10) ||
                    c3_if.rdata !== e.c_rdata || d3_if.rdata !== e.d_rdata) begin
                    errors++;
                    $display("FAIL sb3_ack c/d_ack=%0b%0b c_rdata=%h d_rdata=%h required %s c=%h d=%h",
                             c3_if.ack, d3_if.ack, c3_if.rdata, d3_if.rdata,
                             e.port ? "D" : "C", e.c_rdata, e.d_rdata);
                end
            end
        end
    end

    task automatic test_reset();
        logic [DW-1:0] got [11];
        string names [11];
        names = '{"busy", "mem_ena", "mem_wea", "mem_addra", "mem_dina", "c_ack", "d_ack",
                  "c_rdata", "d_rdata", "busy3", "mem_ena3"};
        got = '{DW'(busy1), DW'(mem_ena1), DW'(mem_wea1), DW'(mem_addra1), mem_dina1,
                DW'(c_if.ack), DW'(d_if.ack), c_if.rdata, d_if.rdata, DW'(busy3),
                DW'(mem_ena3)};
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (got[i] !== '0) begin
                errors++;
                $display("FAIL reset_%s got=%h required 0", names[i], got[i]);
            end
        end
        checks++;
        if (mem_clka1 !== clk || mem_clka3 !== clk) begin
            errors++;
            $display("FAIL reset_mem_clka got=%b/%b required %b", mem_clka1, mem_clka3, clk);
        end
    endtask

    task automatic test_c_write();
        int k = 0;
        bit seen = 0;
        exp_t e;
        @(posedge clk); #1;
        c_if.req = 1'b1; c_if.we = 1'b1; c_if.addr = 7'd5; c_if.wdata = 32'hDEAD_BEEF;
        shadow1[5] = 32'hDEAD_BEEF;
        e = '{port: 1'b0, c_rdata: c_exp1, d_rdata: d_exp1};
        sb1.push_back(e);
        @(negedge clk);
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checks++;
                if ({mem_ena1, mem_wea1, mem_addra1, mem_dina1} !==
                    {1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL c_write_issue ena=%b wea=%b addra=%h dina=%h required 1 1 05 deadbeef",
                             mem_ena1, mem_wea1, mem_addra1, mem_dina1);
                end
            end
            if (k == 2) begin
                checks++;
                if (mem_ena1 !== 1'b0 || mem_wea1 !== 1'b0 || mem_addra1 !== 7'd5) begin
                    errors++;
                    $display("FAIL c_write_hold ena=%b wea=%b addra=%h required 0 0 05",
                             mem_ena1, mem_wea1, mem_addra1);
                end
            end
            seen = c_if.ack;
        end
        checks++;
        if (!seen || k != 2) begin
            errors++;
            $display("FAIL c_write_latency seen=%0b k=%0d required ack at 2", seen, k);
        end
        @(posedge clk); #1;
        c_if.req = 1'b0;
    endtask

    task automatic test_c_read(input logic [AW-1:0] a, input string tag);
        int k = 0;
        bit seen = 0;
        exp_t e;
        @(posedge clk); #1;
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = a; c_if.wdata = 32'h0BAD_0BAD;
        c_exp1 = shadow1[a];
        e = '{port: 1'b0, c_rdata: c_exp1, d_rdata: d_exp1};
        sb1.push_back(e);
        @(negedge clk);
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = c_if.ack;
        end
        checks++;
        if (!seen || k != 3 || c_if.rdata !== shadow1[a] || d_if.rdata !== d_exp1) begin
            errors++;
            $display("FAIL %s seen=%0b k=%0d c_rdata=%h d_rdata=%h required k=3 c=%h d=%h",
                     tag, seen, k, c_if.rdata, d_if.rdata, shadow1[a], d_exp1);
        end
        @(posedge clk); #1;
        c_if.req = 1'b0;
    endtask

    task automatic test_simultaneous();
        int cyc = 0, kc = -1, kd = -1;
        bit ca, da;
        exp_t e;
        @(posedge clk); #1;
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 7'h10; c_if.wdata = '0;
        d_if.req = 1'b1; d_if.we = 1'b1; d_if.addr = 7'h11; d_if.wdata = 32'h0000_1234;
        c_exp1 = shadow1[7'h10];
        e = '{port: 1'b0, c_rdata: c_exp1, d_rdata: d_exp1};
        sb1.push_back(e);
        shadow1[7'h11] = 32'h0000_1234;
        e = '{port: 1'b1, c_rdata: c_exp1, d_rdata: d_exp1};
        sb1.push_back(e);
        while ((kc < 0 || kd < 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ca = c_if.ack;
            da = d_if.ack;
            @(posedge clk); #1;
            if (ca) begin c_if.req = 1'b0; kc = cyc - 1; end
            if (da) begin d_if.req = 1'b0; kd = cyc - 1; end
        end
        c_if.req = 1'b0;
        d_if.req = 1'b0;
        checks++;
        if (kc != 3 || kd != 6) begin
            errors++;
            $display("FAIL simultaneous_order c_ack_at=%0d d_ack_at=%0d required 3 and 6", kc, kd);
        end
    endtask

    task automatic test_d_readback();
        int k = 0;
        bit seen = 0;
        exp_t e;
        @(posedge clk); #1;
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 7'h11;
        d_exp1 = shadow1[7'h11];
        e = '{port: 1'b1, c_rdata: c_exp1, d_rdata: d_exp1};
        sb1.push_back(e);
        @(negedge clk);
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = d_if.ack;
        end
        checks++;
        if (!seen || k != 3 || d_if.rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL d_readback seen=%0b k=%0d d_rdata=%h required k=3 00001234",
                     seen, k, d_if.rdata);
        end
        @(posedge clk); #1;
        d_if.req = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit stray = 0;
        @(posedge clk); #1;
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 7'h05;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1 || mem_ena1 !== 1'b0 || d_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL wait_state busy=%b ena=%b d_ack=%b required 1 0 0",
                     busy1, mem_ena1, d_if.ack);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy1 !== 1'b0 || mem_ena1 !== 1'b0 || d_if.ack !== 1'b0 ||
            d_if.rdata !== '0 || c_if.rdata !== '0 || mem_addra1 !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait busy=%b ena=%b d_ack=%b d_rdata=%h c_rdata=%h addra=%h required all 0",
                     busy1, mem_ena1, d_if.ack, d_if.rdata, c_if.rdata, mem_addra1);
        end
        rst = 1'b1;
        d_if.req = 1'b0;
        c_exp1 = '0;
        d_exp1 = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (d_if.ack || busy1) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL dropped_txn got=ack_or_busy required idle and no d_ack");
        end
        test_c_read(7'd5, "read_after_reset");
    endtask

    task automatic test_starvation();
        int acks = 0, cyc = 0;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e = '{port: (i % 5 == 4), c_rdata: c_exp1, d_rdata: d_exp1};
            sb1.push_back(e);
        end
        shadow1[7'h20] = 32'h1111_0000;
        shadow1[7'h21] = 32'h2222_0000;
        @(posedge clk); #1;
        c_if.req = 1'b1; c_if.we = 1'b1; c_if.addr = 7'h20; c_if.wdata = 32'h1111_0000;
        d_if.req = 1'b1; d_if.we = 1'b1; d_if.addr = 7'h21; d_if.wdata = 32'h2222_0000;
        while (acks < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (c_if.ack || d_if.ack) acks++;
        end
        @(posedge clk); #1;
        c_if.req = 1'b0;
        d_if.req = 1'b0;
        checks++;
        if (acks != 10 || cyc != 30) begin
            errors++;
            $display("FAIL starvation_run acks=%0d last_at=%0d required 10 at 30", acks, cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL starvation_tail busy=%b pending=%0d required 0 0", busy1, sb1.size());
        end
    endtask

    task automatic test_lat3();
        int k = 0;
        bit seen = 0;
        exp_t e;
        @(posedge clk); #1;
        d3_if.req = 1'b1; d3_if.we = 1'b0; d3_if.addr = 7'h7F;
        d_exp3 = shadow3[7'h7F];
        e = '{port: 1'b1, c_rdata: c_exp3, d_rdata: d_exp3};
        sb3.push_back(e);
        @(negedge clk);
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checks++;
                if (mem_ena3 !== 1'b1 || mem_wea3 !== 1'b0 || mem_addra3 !== 7'h7F) begin
                    errors++;
                    $display("FAIL lat3_issue ena=%b wea=%b addra=%h required 1 0 7f",
                             mem_ena3, mem_wea3, mem_addra3);
                end
            end
            seen = d3_if.ack;
        end
        checks++;
        if (!seen || k != 5 || d3_if.rdata !== 32'h3C00_007F || c3_if.rdata !== '0) begin
            errors++;
            $display("FAIL lat3_read seen=%0b k=%0d d_rdata=%h c_rdata=%h required k=5 3c00007f 0",
                     seen, k, d3_if.rdata, c3_if.rdata);
        end
        @(posedge clk); #1;
        d3_if.req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            shadow1[i] = 32'hA500_0000 | DW'(i);
            shadow3[i] = 32'h3C00_0000 | DW'(i);
        end
        c_if.req = 0;  c_if.we = 0;  c_if.addr = '0;  c_if.wdata = '0;
        d_if.req = 0;  d_if.we = 0;  d_if.addr = '0;  d_if.wdata = '0;
        c3_if.req = 0; c3_if.we = 0; c3_if.addr = '0; c3_if.wdata = '0;
        d3_if.req = 0; d3_if.we = 0; d3_if.addr = '0; d3_if.wdata = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        test_c_write();
        test_c_read(7'd5, "c_read_after_write");
        test_simultaneous();
        test_d_readback();
        test_reset_mid_wait();
        test_starvation();
        test_lat3();

        repeat (2) @(negedge clk);
        checks++;
        if (sb1.size() != 0 || sb3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d/%0d required 0/0", sb1.size(), sb3.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
